square16: RTL and testbench
===========================

SQUARE16 -- requirements
Module: square16

Interface
REQ-001 Parameter: WIDTH, 16, operand width; the result width SHALL be 2*WIDTH. Only 16 is required to be supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request a new squaring; sampled on clk rising edge.
REQ-006 U  input  16  unsigned operand; sampled only in the cycle start is accepted.
REQ-007 busy  output  1  high while a computation is in progress.
REQ-008 done  output  1  single-cycle pulse; P is valid in this cycle.
REQ-009 P  output  32  unsigned result U*U; held stable between done pulses.

Function
REQ-010 The block SHALL compute P = U*U exactly as an unsigned value; the maximum result is 0xFFFE0001, so no overflow is possible.
REQ-011 The block SHALL use a three-state FSM: IDLE, RUN and DONE.
REQ-012 IDLE->RUN: when start=1 at an edge, the block SHALL capture U into the operand register, clear the 32-bit accumulator and clear the 4-bit bit counter.
REQ-013 RUN: each edge SHALL examine operand bit[cnt]; if that bit is 1, the block SHALL add (operand << cnt), zero-extended to 32 bits, into the accumulator. It SHALL then increment cnt.
REQ-014 RUN->DONE: on the edge where cnt=15 is processed, the block SHALL load P from the final accumulator value.
REQ-015 Latency: if start is accepted at edge n, P SHALL update and done SHALL be 1 after edge n+16, i.e. exactly 16 cycles after acceptance.
REQ-016 done SHALL be high for exactly one cycle, in state DONE.
REQ-017 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-018 start while in RUN SHALL be ignored, with no queuing and no effect on the current result.
REQ-019 DONE with start=1 SHALL go to RUN, capturing the new U, which gives back-to-back throughput of one result per 17 cycles.
REQ-020 DONE with start=0 SHALL go to IDLE.
REQ-021 P SHALL keep its last value until the next DONE; intermediate accumulator values SHALL never appear on P.
REQ-022 Changes on U outside the acceptance cycle SHALL NOT affect the result.
REQ-023 U=0 SHALL still take the full 16 cycles and produce P=0 with a done pulse.

Reset
REQ-024 When rst is asserted, regardless of clk, the block SHALL set: state=IDLE, busy=0, done=0, P=0, accumulator=0, cnt=0, operand=0.
REQ-025 Reset during RUN SHALL abort the computation: no done pulse and P=0.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-027 Package square16_pkg SHALL hold: WIDTH, the result width constant, the counter width constant (4), and the FSM state enum (IDLE, RUN, DONE).
REQ-028 The shift-add datapath SHALL be a sub-module, square16_acc, containing the accumulator, the conditional adder and the shifter.
REQ-029 The FSM and counter SHALL stay in square16.
REQ-030 Only P and done SHALL be registered outputs visible to downstream logic; busy SHALL be derived from the state register.
REQ-031 Target size is about 150-250 lines of RTL in total.

Verification
REQ-032 U=0x0004 with a start pulse -> done exactly 16 cycles later, P=0x00000010, busy high for 16 cycles.
REQ-033 U=0xFFFF -> P=0xFFFE0001; U=0x0008 -> P=0x00000040; U=0x8000 -> P=0x40000000.
REQ-034 Start U=0x0003, then pulse start with U=0x0100 at cycle 5 of RUN -> only a single done, with P=0x00000009.
REQ-035 Assert rst at cycle 8 of RUN with U=0x1234 -> done never pulses, P=0, busy=0 immediately without waiting for an edge.
REQ-036 Hold start=1 continuously with U=0x0002, then 0x0005 -> done pulses 17 cycles apart, with P=4 then P=25 and no idle cycle between.
REQ-037 Round trip: for all 256 values i, drive U={i,i} into square16 and the resulting P into sqrt32 -> sqrt32 SHALL return U unchanged.

Source files
------------

// File: rtl/square16_pkg.sv
// Shared constants and FSM state type for the square16 shift-add squarer.
package square16_pkg;

    // Operand width and derived result width.
    localparam int WIDTH     = 16;
    localparam int P_WIDTH   = 2 * WIDTH;

    // Bit counter walks operand bits 0..15.
    localparam int CNT_WIDTH = 4;

    // Control states of the squarer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/square16_acc.sv
// Shift-add datapath: operand register, shifter, conditional adder and accumulator.
// The combinational acc_next is the accumulator value after the current bit is
// folded in, so the controller can load the final product on the last step
// without an extra cycle.
module square16_acc
    import square16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     u,
    input  logic [CNT_WIDTH-1:0] cnt,
    output logic [P_WIDTH-1:0]   acc_next
);

    logic [WIDTH-1:0]   operand_reg;
    logic [P_WIDTH-1:0] acc_reg;
    logic [P_WIDTH-1:0] operand_ext;
    logic [P_WIDTH-1:0] shifted [WIDTH];
    logic [P_WIDTH-1:0] addend;

    assign operand_ext = {{(P_WIDTH - WIDTH){1'b0}}, operand_reg};

    // One pre-shifted copy of the operand per bit position; cnt selects one.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            assign shifted[gi] = operand_ext << gi;
        end
    endgenerate

    // Add the shifted operand only when the examined operand bit is set.
    always_comb begin
        addend   = '0;
        if (operand_reg[cnt]) begin
            addend = shifted[cnt];
        end
        acc_next = acc_reg + addend;
    end

    // Capture operand and clear the sum on acceptance; accumulate while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_reg <= '0;
            acc_reg     <= '0;
        end else if (load) begin
            operand_reg <= u;
            acc_reg     <= '0;
        end else if (step) begin
            acc_reg     <= acc_next;
        end
    end

endmodule

// File: rtl/square16.sv
// Sequential unsigned squarer: P = U*U in 16 RUN cycles using one adder.
// The FSM and bit counter live here; the shift-add datapath is square16_acc.
// P and done are registered; busy is decoded from the state register so it
// drops as soon as reset is applied.
module square16 #(
    parameter int WIDTH = square16_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     U,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    import square16_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                 state_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   done_reg;
    logic [2*WIDTH-1:0]     p_reg;

    logic                   load;
    logic                   step;
    logic [P_WIDTH-1:0]     acc_next;

    // A new operand is accepted from IDLE or DONE; start during RUN is ignored.
    assign load = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign step = (state_reg == RUN);

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign P    = p_reg;

    square16_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .u        (U),
        .cnt      (cnt_reg),
        .acc_next (acc_next)
    );

    // Control FSM: sequence the 16 bit steps and publish the result once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            p_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                    if (cnt_reg == CNT_LAST) begin
                        p_reg     <= acc_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square16.sv
// Self-checking bench for square16: directed corner cases plus random operands
// checked against plain arithmetic (U*U, integer square root round trip).
module tb_square16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] U;
    logic        busy;
    logic        done;
    logic [31:0] P;

    int n_checks = 0;
    int n_fail   = 0;

    square16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .U     (U),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Integer square root by binary search.
    function automatic logic [31:0] isqrt(input logic [31:0] v);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid;
        end
        return 32'(lo);
    endfunction

    // Present an operand with start for one edge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] u);
        @(negedge clk);
        start = 1'b1;
        U     = u;
        @(posedge clk);
    endtask

    // Observe up to max_k negedges after acceptance. k=0 is the cycle right
    // after the accepting edge. Optionally pulses start at cycle inject_k.
    task automatic run_wait(input int inject_k, input logic [15:0] inject_u, input int max_k,
                            output int lat, output int busy_cnt, output int dones,
                            output logic [31:0] p_done);
        lat      = -1;
        busy_cnt = 0;
        dones    = 0;
        p_done   = 32'hxxxx_xxxx;
        for (int k = 0; k < max_k; k++) begin
            @(negedge clk);
            start = (k == inject_k);
            U     = (k == inject_k) ? inject_u : 16'($urandom);
            if (done) begin
                if (dones == 0) begin
                    lat    = k;
                    p_done = P;
                end
                dones++;
            end else if (dones == 0) begin
                busy_cnt += int'(busy);
            end
        end
        start = 1'b0;
    endtask

    task automatic one_square(input string tag, input logic [15:0] u);
        int lat, bc, nd;
        logic [31:0] pd;
        logic [31:0] exp_p;
        exp_p = 32'(u) * 32'(u);
        issue(u);
        run_wait(-1, 16'h0, 17, lat, bc, nd, pd);
        check({tag, "_lat"}, 32'(lat), 32'd16);
        check({tag, "_p"}, pd, exp_p);
        $display("op %s U=0x%04h P=0x%08h latency=%0d", tag, u, pd, lat);
    endtask

    initial begin
        int lat, bc, nd, d1, d2, bc_between;
        logic [31:0] pd, p1, p2;
        logic [15:0] ru;
        logic [15:0] rt;
        logic [7:0]  b8;

        rst   = 1'b1;
        start = 1'b0;
        U     = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_p", P, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        $display("op reset P=0x%08h done=%0b busy=%0b", P, done, busy);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'h0);

        // Basic operand 4: latency, busy width, value, single pulse.
        issue(16'h0004);
        run_wait(-1, 16'h0, 17, lat, bc, nd, pd);
        check("u4_lat", 32'(lat), 32'd16);
        check("u4_busy_cycles", 32'(bc), 32'd16);
        check("u4_p", pd, 32'h0000_0010);
        @(negedge clk);
        check("u4_done_single", 32'(done), 32'h0);
        check("u4_p_hold", P, 32'h0000_0010);
        check("u4_idle", 32'(busy), 32'h0);
        $display("op U=0x0004 P=0x%08h latency=%0d busy_cycles=%0d", pd, lat, bc);

        // Directed corners, including zero operand.
        one_square("u_ffff", 16'hFFFF);
        one_square("u_0008", 16'h0008);
        one_square("u_8000", 16'h8000);
        one_square("u_0000", 16'h0000);
        one_square("u_0001", 16'h0001);

        // Random operands.
        for (int i = 0; i < 24; i++) begin
            ru = 16'($urandom);
            one_square("rand", ru);
        end

        // Round trip: sqrt of the product returns the operand.
        for (int i = 0; i < 256; i++) begin
            b8 = 8'(i);
            rt = {b8, b8};
            issue(rt);
            run_wait(-1, 16'h0, 17, lat, bc, nd, pd);
            check("roundtrip_lat", 32'(lat), 32'd16);
            check("roundtrip_sqrt", isqrt(pd), 32'(rt));
            $display("op roundtrip U=0x%04h P=0x%08h sqrt=0x%04h", rt, pd, isqrt(pd));
        end

        // Start during RUN is ignored.
        issue(16'h0003);
        run_wait(5, 16'h0100, 40, lat, bc, nd, pd);
        check("ignore_lat", 32'(lat), 32'd16);
        check("ignore_p", pd, 32'h0000_0009);
        check("ignore_dones", 32'(nd), 32'd1);
        check("ignore_p_final", P, 32'h0000_0009);
        $display("op start-in-run U=0x0003 P=0x%08h dones=%0d", pd, nd);

        // Asynchronous reset mid-computation aborts it.
        issue(16'h1234);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_p", P, 32'h0);
        check("abort_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            nd += int'(done);
        end
        check("abort_no_done", 32'(nd), 32'h0);
        check("abort_p_after", P, 32'h0);
        $display("op abort U=0x1234 P=0x%08h dones=%0d", P, nd);

        // First start after reset is accepted normally.
        one_square("post_rst", 16'h0007);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        U     = 16'h0002;
        @(posedge clk);
        d1 = -1;
        d2 = -1;
        p1 = 32'h0;
        p2 = 32'h0;
        bc_between = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (d1 >= 0 && d2 < 0 && !done) bc_between += int'(busy);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    p1 = P;
                    U  = 16'h0005;
                end else if (d2 < 0) begin
                    d2 = k;
                    p2 = P;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_lat", 32'(d1), 32'd16);
        check("b2b_spacing", 32'(d2 - d1), 32'd17);
        check("b2b_p1", p1, 32'd4);
        check("b2b_p2", p2, 32'd25);
        check("b2b_busy_between", 32'(bc_between), 32'd16);
        $display("op back-to-back P1=%0d P2=%0d spacing=%0d", p1, p2, d2 - d1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
